// File: rtl/rc_ring_out_arb.sv
// Ring output arbiter: ring pass-through first, then F2C/C2F with a response burst cap; slot is registered (1 cycle).
// Local heads are popped by same-cycle grants; ring traffic is never stalled, local starvation raises RingThrottle.
module rc_ring_out_arb #(
  parameter int MSG_W        = 66,
  parameter int RESP_BURST   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             QClk,
  input  logic             RstQnnnH,
  input  logic             RingInValid,
  input  logic             RingInConsume,
  input  logic [MSG_W-1:0] RingInMsg,
  input  logic             F2cValid,
  input  logic [MSG_W-1:0] F2cMsg,
  input  logic             C2fValid,
  input  logic [MSG_W-1:0] C2fMsg,
  output logic             F2cGnt,
  output logic             C2fGnt,
  output logic             RingOutValid,
  output logic [MSG_W-1:0] RingOutMsg,
  output logic [1:0]       RingOutWinner,
  output logic             RingThrottle
);

  localparam int RS_W = $clog2(RESP_BURST + 1);
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [RS_W-1:0] RESP_MAX   = RS_W'(RESP_BURST);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    BUBBLE_OUT   = 2'd0,
    RING_INPUT   = 2'd1,
    F2C_RESPONSE = 2'd2,
    C2F_REQUEST  = 2'd3
  } t_winner;

  typedef enum logic {
    ARB_NORMAL  = 1'b0,
    ARB_STARVED = 1'b1
  } t_arb_state;

  t_winner          winner;
  t_arb_state       state, state_nxt;
  logic [RS_W-1:0]  resp_streak, resp_streak_nxt;
  logic [SC_W-1:0]  starve_cnt, starve_cnt_nxt;
  logic             local_pend;
  logic             local_gnt;
  logic [MSG_W-1:0] sel_msg;

  assign local_pend = F2cValid | C2fValid;

  always_comb begin
    winner = BUBBLE_OUT;
    if (RingInValid && !RingInConsume) begin
      winner = RING_INPUT;
    end else if (F2cValid && C2fValid) begin
      // Once F2C has used its burst, the pending request gets the slot.
      winner = (resp_streak == RESP_MAX) ? C2F_REQUEST : F2C_RESPONSE;
    end else if (F2cValid) begin
      winner = F2C_RESPONSE;
    end else if (C2fValid) begin
      winner = C2F_REQUEST;
    end
  end

  // Grants are suppressed during reset so queue heads are not lost.
  assign F2cGnt    = !RstQnnnH && (winner == F2C_RESPONSE);
  assign C2fGnt    = !RstQnnnH && (winner == C2F_REQUEST);
  assign local_gnt = F2cGnt | C2fGnt;

  always_comb begin
    sel_msg = '0;
    case (winner)
      RING_INPUT:   sel_msg = RingInMsg;
      F2C_RESPONSE: sel_msg = F2cMsg;
      C2F_REQUEST:  sel_msg = C2fMsg;
      default:      sel_msg = '0;
    endcase
  end

  always_comb begin
    resp_streak_nxt = resp_streak;
    if (C2fGnt || !C2fValid) begin
      resp_streak_nxt = '0;
    end else if (F2cGnt && resp_streak != RESP_MAX) begin
      resp_streak_nxt = resp_streak + 1'b1;
    end
  end

  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (local_gnt || !local_pend) begin
      starve_cnt_nxt = '0;
    end else if (winner == RING_INPUT && starve_cnt != STARVE_MAX) begin
      starve_cnt_nxt = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge QClk or posedge RstQnnnH) begin
    if (RstQnnnH) begin
      state <= ARB_NORMAL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_NORMAL: begin
        if (starve_cnt == STARVE_MAX && local_pend && !local_gnt) begin
          state_nxt = ARB_STARVED;
        end
      end
      ARB_STARVED: begin
        if (local_gnt || !local_pend) begin
          state_nxt = ARB_NORMAL;
        end
      end
      default: state_nxt = ARB_NORMAL;
    endcase
  end

  always_comb begin
    RingThrottle = (state == ARB_STARVED);
  end

  always_ff @(posedge QClk or posedge RstQnnnH) begin
    if (RstQnnnH) begin
      resp_streak   <= '0;
      starve_cnt    <= '0;
      RingOutValid  <= 1'b0;
      RingOutMsg    <= '0;
      RingOutWinner <= BUBBLE_OUT;
    end else begin
      resp_streak   <= resp_streak_nxt;
      starve_cnt    <= starve_cnt_nxt;
      RingOutValid  <= (winner != BUBBLE_OUT);
      RingOutMsg    <= sel_msg;
      RingOutWinner <= winner;
    end
  end

endmodule

// File: tb/tb_rc_ring_out_arb.sv
// Bench for rc_ring_out_arb: vector table, directed corner sequences and a randomized run against a reference model.
module tb_rc_ring_out_arb;

  localparam int MSG_W = 66;
  localparam int RB    = 2;
  localparam int SL    = 8;
  localparam logic [1:0] W_BUB  = 2'd0;
  localparam logic [1:0] W_RING = 2'd1;
  localparam logic [1:0] W_F2C  = 2'd2;
  localparam logic [1:0] W_C2F  = 2'd3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ring_v = 1'b0, ring_c = 1'b0, f_v = 1'b0, c_v = 1'b0;
  logic [MSG_W-1:0] ring_m = '0, f_m = '0, c_m = '0;
  logic             f_gnt, c_gnt, out_v, thr;
  logic [MSG_W-1:0] out_m;
  logic [1:0]       out_w;

  int n_chk  = 0;
  int n_fail = 0;

  rc_ring_out_arb #(.MSG_W(MSG_W), .RESP_BURST(RB), .STARVE_LIMIT(SL)) dut (
    .QClk(clk), .RstQnnnH(rst),
    .RingInValid(ring_v), .RingInConsume(ring_c), .RingInMsg(ring_m),
    .F2cValid(f_v), .F2cMsg(f_m), .C2fValid(c_v), .C2fMsg(c_m),
    .F2cGnt(f_gnt), .C2fGnt(c_gnt),
    .RingOutValid(out_v), .RingOutMsg(out_m), .RingOutWinner(out_w),
    .RingThrottle(thr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rv, rc, fv, cv;
    logic [1:0] w;
    logic       fg, cg;
  } vec_t;

  task automatic chk(input string name, input logic [MSG_W-1:0] act, input logic [MSG_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic rv, input logic rc, input logic fv, input logic cv);
    ring_v = rv; ring_c = rc; f_v = fv; c_v = cv;
  endtask

  function automatic logic [MSG_W-1:0] pick(input logic [1:0] w);
    case (w)
      W_RING:  return ring_m;
      W_F2C:   return f_m;
      W_C2F:   return c_m;
      default: return '0;
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    vec_t vecs[11];
    logic [1:0]       exp_w;
    logic             exp_v;
    logic [MSG_W-1:0] exp_m;
    logic [1:0]       w;
    int               run, frun, ring_pct, cons_pct;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, W_BUB,  1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, W_RING, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, W_RING, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, W_BUB,  1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, W_F2C,  1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, W_C2F,  1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, W_F2C,  1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, W_F2C,  1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, W_C2F,  1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, W_F2C,  1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, W_BUB,  1'b0, 1'b0};

    ring_m = {2'd1, 32'h1000_0000, 32'hAAAA_0001};
    f_m    = {2'd0, 32'h2000_0004, 32'hBBBB_0002};
    c_m    = {2'd3, 32'h3000_0008, 32'hCCCC_0003};

    // Reset held with everything valid: nothing granted, outputs at reset values.
    set_in(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_f2c_gnt", f_gnt, 0);
      chk("reset_c2f_gnt", c_gnt, 0);
      chk("reset_out_valid", out_v, 0);
      chk("reset_out_winner", out_w, W_BUB);
      chk("reset_out_msg", out_m, 0);
      chk("reset_throttle", thr, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    for (int i = 0; i < 11; i++) begin
      set_in(vecs[i].rv, vecs[i].rc, vecs[i].fv, vecs[i].cv);
      @(negedge clk);
      chk($sformatf("vec%0d_f2c_gnt", i), f_gnt, vecs[i].fg);
      chk($sformatf("vec%0d_c2f_gnt", i), c_gnt, vecs[i].cg);
      exp_m = pick(vecs[i].w);
      tick();
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d_winner", i), out_w, vecs[i].w);
      chk($sformatf("vec%0d_valid", i), out_v, vecs[i].w != W_BUB);
      chk($sformatf("vec%0d_msg", i), out_m, exp_m);
      tick();
    end

    // Consume and refill: freed slot goes to the C2F head in the same cycle.
    c_m = 66'h2_00000400_DEADBEEF;
    set_in(1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("refill_c2f_gnt", c_gnt, 1);
    chk("refill_f2c_gnt", f_gnt, 0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("refill_winner", out_w, W_C2F);
    chk("refill_msg", out_m, 66'h2_00000400_DEADBEEF);
    chk("refill_valid", out_v, 1);
    tick();

    // Fairness: F,F,C repeating while both queues stay valid.
    set_in(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk($sformatf("fair%0d_f2c_gnt", i), f_gnt, (i % 3) != 2);
      chk($sformatf("fair%0d_c2f_gnt", i), c_gnt, (i % 3) == 2);
      tick();
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Starvation: throttle rises on cycle 9, falls the cycle after the first grant.
    set_in(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk($sformatf("starve%0d_throttle", i), thr, i >= 9);
      chk($sformatf("starve%0d_f2c_gnt", i), f_gnt, 0);
      if (i >= 1) begin
        chk($sformatf("starve%0d_winner", i), out_w, W_RING);
        chk($sformatf("starve%0d_msg", i), out_m, ring_m);
      end
      tick();
    end
    ring_v = 1'b0;
    @(negedge clk);
    chk("unstarve_f2c_gnt", f_gnt, 1);
    chk("unstarve_throttle_held", thr, 1);
    tick();
    f_v = 1'b0;
    @(negedge clk);
    chk("unstarve_throttle_drop", thr, 0);
    chk("unstarve_winner", out_w, W_F2C);
    tick();

    // Asynchronous reset while throttled and busy.
    set_in(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk);
    chk("pre_areset_throttle", thr, 1);
    rst = 1'b1;
    #1;
    chk("areset_throttle", thr, 0);
    chk("areset_valid", out_v, 0);
    chk("areset_winner", out_w, W_BUB);
    chk("areset_msg", out_m, 0);
    chk("areset_f2c_gnt", f_gnt, 0);
    chk("areset_c2f_gnt", c_gnt, 0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("idle_winner", out_w, W_BUB);
    chk("idle_valid", out_v, 0);
    tick();

    // Randomized run against the reference model, with varying ring load.
    exp_w = W_BUB; exp_v = 1'b0; exp_m = '0;
    run = 0; frun = 0;
    ring_pct = 20; cons_pct = 30;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 250 == 0) begin
        case ((cyc / 250) % 3)
          0: begin ring_pct = 20; cons_pct = 30; end
          1: begin ring_pct = 60; cons_pct = 20; end
          default: begin ring_pct = 97; cons_pct = 3; end
        endcase
      end
      ring_v = ($urandom_range(0, 99) < ring_pct);
      ring_c = ($urandom_range(0, 99) < cons_pct);
      f_v    = ($urandom_range(0, 99) < 60);
      c_v    = ($urandom_range(0, 99) < 50);
      ring_m = {2'($urandom), $urandom, $urandom};
      f_m    = {2'($urandom), $urandom, $urandom};
      c_m    = {2'($urandom), $urandom, $urandom};
      @(negedge clk);
      if (ring_v && !ring_c)   w = W_RING;
      else if (f_v && c_v)     w = (frun >= RB) ? W_C2F : W_F2C;
      else if (f_v)            w = W_F2C;
      else if (c_v)            w = W_C2F;
      else                     w = W_BUB;
      chk("rnd_f2c_gnt", f_gnt, w == W_F2C);
      chk("rnd_c2f_gnt", c_gnt, w == W_C2F);
      chk("rnd_out_valid", out_v, exp_v);
      chk("rnd_out_winner", out_w, exp_w);
      chk("rnd_out_msg", out_m, exp_m);
      chk("rnd_throttle", thr, run >= SL + 1);
      exp_w = w;
      exp_v = (w != W_BUB);
      exp_m = pick(w);
      run   = ((f_v || c_v) && w == W_RING) ? run + 1 : 0;
      if (w == W_C2F || !c_v) frun = 0;
      else if (w == W_F2C)    frun = frun + 1;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
